// File: rtl/spi_burst_pkg.sv
// Shared types and constants for the SPI burst sequencer: FSM encoding,
// command mode codes and the default rx-only fill byte.
package spi_burst_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_FETCH,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CAPTURE,
    S_CS_HOLD
  } state_e;

  localparam logic [1:0] MODE_DUPLEX  = 2'b00;
  localparam logic [1:0] MODE_TX_ONLY = 2'b01;
  localparam logic [1:0] MODE_RX_ONLY = 2'b10;

  localparam logic [7:0] DEFAULT_FILL_BYTE = 8'hFF;

  // The reserved mode code 2'b11 behaves as full-duplex.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'b11) ? MODE_DUPLEX : mode;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; push and pop may coincide
// at any fill level, including full and empty.
module byte_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  push_data,
  input  logic        pop,
  output logic [7:0]  pop_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push;
  logic        do_pop;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level    = wptr_q - rptr_q;
  assign pop_data = mem_q[rptr_q[AW-1:0]];

  // A pop frees the slot being written, so push is allowed at full when popping.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) wptr_d = wptr_q + (AW+1)'(1);
    if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Multi-byte burst engine in front of an SPI master core: feeds bytes from a
// TX FIFO, collects results into an RX FIFO and frames the burst with CS.
module spi_burst_sequencer
  import spi_burst_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned LEN_W         = 16,
  parameter logic [7:0]  FILL_BYTE     = DEFAULT_FILL_BYTE,
  parameter int unsigned CS_GUARD      = 2,
  parameter int unsigned START_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [1:0]       cmd_mode,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [7:0]       tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [7:0]       rx_data,
  output logic             spi_start,
  output logic [7:0]       spi_tx_data,
  input  logic [7:0]       spi_rx_data,
  input  logic             spi_busy,
  input  logic             spi_ready,
  output logic             spi_cs_n,
  output logic             done,
  output logic             err_timeout,
  output logic [LEN_W-1:0] bytes_left
);

  localparam int unsigned GW = (CS_GUARD > 1) ? $clog2(CS_GUARD) : 1;
  localparam int unsigned TW = $clog2(START_TIMEOUT);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [LEN_W-1:0] bytes_left_q, bytes_left_d;
  logic [GW-1:0]    guard_q, guard_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             spi_start_q, spi_start_d;
  logic [7:0]       spi_tx_data_q, spi_tx_data_d;
  logic             spi_cs_n_q, spi_cs_n_d;
  logic             done_q, done_d;
  logic             err_timeout_q, err_timeout_d;

  logic             tx_pop, tx_full, tx_empty;
  logic             rx_push, rx_full, rx_empty;
  logic [7:0]       tx_rdata;
  logic [LW-1:0]    tx_level_unused, rx_level_unused;
  logic             rx_room, tx_avail;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .push(tx_valid && tx_ready), .push_data(tx_data),
    .pop(tx_pop), .pop_data(tx_rdata),
    .full(tx_full), .empty(tx_empty), .level(tx_level_unused)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .push(rx_push), .push_data(spi_rx_data),
    .pop(rx_valid && rx_ready), .pop_data(rx_data),
    .full(rx_full), .empty(rx_empty), .level(rx_level_unused)
  );

  assign tx_ready    = !tx_full;
  assign rx_valid    = !rx_empty;
  assign cmd_ready   = (state_q == S_IDLE);
  assign spi_start   = spi_start_q;
  assign spi_tx_data = spi_tx_data_q;
  assign spi_cs_n    = spi_cs_n_q;
  assign done        = done_q;
  assign err_timeout = err_timeout_q;
  assign bytes_left  = bytes_left_q;

  assign rx_room  = !rx_full || (mode_q == MODE_TX_ONLY);
  assign tx_avail = !tx_empty || (mode_q == MODE_RX_ONLY);

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    bytes_left_d  = bytes_left_q;
    guard_d       = guard_q;
    timer_d       = timer_q;
    spi_start_d   = 1'b0;
    spi_tx_data_d = spi_tx_data_q;
    spi_cs_n_d    = spi_cs_n_q;
    done_d        = 1'b0;
    err_timeout_d = err_timeout_q;
    tx_pop        = 1'b0;
    rx_push       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          mode_d        = norm_mode(cmd_mode);
          bytes_left_d  = cmd_len;
          err_timeout_d = 1'b0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = S_CS_SETUP;
            spi_cs_n_d = 1'b0;
            guard_d    = GW'(CS_GUARD - 1);
          end
        end
      end
      S_CS_SETUP: begin
        if (guard_q == '0) state_d = S_FETCH;
        else               guard_d = guard_q - GW'(1);
      end
      // Stalls indefinitely until both data and result space are available.
      S_FETCH: begin
        if (rx_room && tx_avail) begin
          tx_pop        = (mode_q != MODE_RX_ONLY);
          spi_tx_data_d = (mode_q == MODE_RX_ONLY) ? FILL_BYTE : tx_rdata;
          spi_start_d   = 1'b1;
          state_d       = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (spi_busy) begin
          state_d = S_WAIT_DONE;
        end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = S_CS_HOLD;
          guard_d       = GW'(CS_GUARD - 1);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!spi_busy && spi_ready) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        rx_push      = (mode_q != MODE_TX_ONLY);
        bytes_left_d = bytes_left_q - LEN_W'(1);
        if (bytes_left_q == LEN_W'(1)) begin
          state_d = S_CS_HOLD;
          guard_d = GW'(CS_GUARD - 1);
        end else begin
          state_d = S_FETCH;
        end
      end
      S_CS_HOLD: begin
        if (guard_q == '0) begin
          spi_cs_n_d = 1'b1;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mode_q        <= MODE_DUPLEX;
      bytes_left_q  <= '0;
      guard_q       <= '0;
      timer_q       <= '0;
      spi_start_q   <= 1'b0;
      spi_tx_data_q <= '0;
      spi_cs_n_q    <= 1'b1;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      bytes_left_q  <= bytes_left_d;
      guard_q       <= guard_d;
      timer_q       <= timer_d;
      spi_start_q   <= spi_start_d;
      spi_tx_data_q <= spi_tx_data_d;
      spi_cs_n_q    <= spi_cs_n_d;
      done_q        <= done_d;
      err_timeout_q <= err_timeout_d;
    end
  end

endmodule

// File: doc/spi_burst_sequencer.md
Name: spi_burst_sequencer

Overview:
Multi-byte transfer engine directly upstream of the SPI master core. It consumes byte streams and a burst command, and drives the core's start/tx_data handshake one byte at a time. It collects rx_data into an RX FIFO and controls chip-select around the whole burst. It relieves the CPU from polling busy/ready per byte.

Parameters:
FIFO_DEPTH, 8, entries in each of the TX and RX byte FIFOs (power of 2, >=2)
LEN_W, 16, width of the burst length field
FILL_BYTE, 8'hFF, byte sent on MOSI in rx-only mode
CS_GUARD, 2, clk cycles between the CS edge and the first start, and between the last byte and CS release
START_TIMEOUT, 255, clk cycles allowed for spi_busy to rise after spi_start

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  burst command valid
cmd_ready  out  1  high only in IDLE
cmd_len  in  LEN_W  number of bytes in the burst
cmd_mode  in  2  00 full-duplex, 01 tx-only (RX discarded), 10 rx-only (FILL_BYTE sent), 11 treated as 00
tx_valid / tx_ready / tx_data  in/out/in  1/1/8  TX byte stream into the TX FIFO
rx_valid / rx_ready / rx_data  out/in/out  1/1/8  RX byte stream out of the RX FIFO
spi_start  out  1  start request to the SPI master core
spi_tx_data  out  8  byte to transmit
spi_rx_data  in  8  last received byte
spi_busy  in  1  core busy (already synchronous to clk)
spi_ready  in  1  core idle / result valid
spi_cs_n  out  1  chip-select, active-low
done  out  1  one-cycle pulse at burst end
err_timeout  out  1  sticky; cleared on the next accepted command
bytes_left  out  LEN_W  remaining byte count

Behaviour:
- Reset values: FSM IDLE, both FIFOs empty, spi_start=0, spi_tx_data=0, spi_cs_n=1, done=0, err_timeout=0, bytes_left=0, rx_valid=0.
- Timing: all outputs are registered except the FIFO ready/valid flags, which are derived from registered pointers.
- FIFOs: the TX and RX FIFOs operate independently of the FSM.
  - tx_ready = !tx_full. rx_valid = !rx_empty.
  - Simultaneous push and pop in the same cycle is legal at any fill level, including full and empty.
  - Pointers use an extra wrap bit.
- FSM states: IDLE, CS_SETUP, FETCH, START, WAIT_BUSY, WAIT_DONE, CAPTURE, CS_HOLD.
- IDLE: on cmd_valid && cmd_ready, latch mode and len, and clear err_timeout.
  - len==0: pulse done the next cycle, stay IDLE, CS untouched.
  - Otherwise: go to CS_SETUP, spi_cs_n=0, load the guard counter.
- CS_SETUP: wait CS_GUARD cycles, then go to FETCH.
- FETCH: a byte may start only when both of these hold:
  - the RX FIFO is not full, or the mode is tx-only;
  - TX data is present, or the mode is rx-only.
  - On start: pop TX (except in rx-only), drive spi_tx_data, go to START. Otherwise stall in FETCH with no timeout.
- START: spi_start=1 for exactly one cycle, go to WAIT_BUSY.
- WAIT_BUSY: hold until spi_busy=1, then go to WAIT_DONE.
  - If START_TIMEOUT cycles elapse first: set err_timeout, go to CS_HOLD, abort the burst, and leave bytes_left at its value.
- WAIT_DONE: wait for spi_busy=0 && spi_ready=1, then go to CAPTURE.
- CAPTURE: push spi_rx_data to the RX FIFO (except in tx-only) and decrement bytes_left.
  - bytes_left becomes 0: go to CS_HOLD.
  - Otherwise: go to FETCH.
- CS_HOLD: wait CS_GUARD cycles, set spi_cs_n=1, pulse done, go to IDLE.
- Pacing: minimum inter-byte gap is FETCH+START+CAPTURE = 3 cycles plus core time. spi_cs_n stays low continuously for the whole burst.
- Bytes beyond len: TX FIFO contents left over after a burst stay queued for the next command. They are never sent without a command.
- Reset mid-burst: synchronous rst returns everything to reset values in the next cycle. spi_cs_n=1 immediately, and both FIFOs are flushed.
- cmd_valid while not IDLE: not accepted (cmd_ready=0).

Decomposition:
- Package spi_burst_pkg holds:
  - FSM state encoding;
  - cmd_mode constants MODE_DUPLEX, MODE_TX_ONLY, MODE_RX_ONLY;
  - default FILL_BYTE.
- One sub-module: byte_fifo (parameter DEPTH; push/pop, full/empty, level). It is instantiated twice, for TX and RX.

Test Plan:
- Full-duplex burst: push 0xA5, 0x3C, 0x81; cmd len=3 mode=00; the core model echoes the inverted byte.
  - Expect: three spi_start pulses with tx 0xA5/0x3C/0x81.
  - Expect: RX stream 0x5A/0xC3/0x7E.
  - Expect: spi_cs_n low continuously; done once; bytes_left=0.
- Rx-only burst: len=4 mode=10 with the TX FIFO empty.
  - Expect: spi_tx_data=0xFF for all 4 bytes.
  - Expect: 4 RX entries, TX FIFO untouched.
- Backpressure: len=10 with rx_ready=0.
  - Expect: 8 bytes captured, then the FSM stalls in FETCH with CS low.
  - Then raise rx_ready: remaining 2 bytes complete, done pulses.
- Zero length: cmd len=0.
  - Expect: done pulse 1 cycle after acceptance, spi_cs_n stays 1, no spi_start.
- Timeout: the core model never raises spi_busy.
  - Expect: err_timeout=1 after 255 cycles, CS released after CS_GUARD, done pulses, bytes_left unchanged.
  - Then a new command: expect err_timeout cleared.
- Reset mid-burst: assert rst during WAIT_DONE of byte 2 of 5.
  - Expect next cycle: spi_cs_n=1, spi_start=0, FIFOs empty, cmd_ready=1.
